// File: rtl/mem_interface.sv
// Wait-stated single-port RAM stage behind the CPU MAR/MDR path with a Done handshake.
// Optional write protection of the low words is enabled by defining MEM_PROTECT_EN.
module mem_interface #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2,
    parameter int PROTECT_TOP = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_mem_err
);

    // state    | meaning
    // S_IDLE   | waiting for Read/Write, request latched on exit
    // S_WAIT   | counting wait states down to zero
    // S_ACCESS | single RAM read or write cycle
    // S_DONE   | Done high until both request levels are released
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int IDX_W = $clog2(DEPTH);
`ifdef MEM_PROTECT_EN
    localparam logic PROT_ON = 1'b1;
`else
    localparam logic PROT_ON = 1'b0;
`endif

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_is_write;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic             w_req;
    logic             w_in_range;
    logic             w_protected;
    logic             w_commit;
    logic [IDX_W-1:0] w_idx;

    assign w_req       = i_read | i_write;
    assign w_in_range  = 32'(r_addr) < DEPTH;
    assign w_protected = PROT_ON & (32'(r_addr) < PROTECT_TOP);
    assign w_idx       = r_addr[IDX_W-1:0];
    assign w_commit    = (r_state == S_ACCESS) && r_is_write && w_in_range && !w_protected;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_is_write <= 1'b0;
            o_rd_data  <= '0;
            o_done     <= 1'b0;
            o_busy     <= 1'b0;
            o_mem_err  <= 1'b0;
        end else begin
            o_mem_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr     <= i_addr;
                        r_wr_data  <= i_wr_data;
                        r_is_write <= i_write;
                        r_cnt      <= 4'(WAIT_CYCLES);
                        r_state    <= S_WAIT;
                        o_busy     <= 1'b1;
                    end
                end
                // WAIT always runs once even with zero wait states, keeping Done at WAIT_CYCLES+2 edges
                S_WAIT: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                    else r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (!r_is_write) o_rd_data <= w_in_range ? r_mem[w_idx] : '0;
                    o_mem_err <= r_is_write && w_in_range && w_protected;
                    o_done    <= 1'b1;
                    r_state   <= S_DONE;
                end
                default: begin
                    if (!w_req) begin
                        o_done  <= 1'b0;
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // RAM contents deliberately survive reset
    always_ff @(posedge i_clk) begin
        if (w_commit) r_mem[w_idx] <= r_wr_data;
    end

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance share stimulus;
// read data is checked against a queue of expected values derived from a word model.
module tb_mem_interface;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata, rdata0;
    logic        done, busy, merr, done0, busy0, merr0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl [int];
    int lat, lat0;
    logic err, err0;
    logic [31:0] base5;

    always #5 clk = ~clk;

    mem_interface dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_read(rd), .i_write(wr), .i_addr(addr),
        .i_wr_data(wdata), .o_rd_data(rdata), .o_done(done), .o_busy(busy), .o_mem_err(merr)
    );

    mem_interface #(.WAIT_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_read(rd), .i_write(wr), .i_addr(addr),
        .i_wr_data(wdata), .o_rd_data(rdata0), .o_done(done0), .o_busy(busy0), .o_mem_err(merr0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drives one request at a negedge and holds it until Done (bounded); leaves request asserted.
    task automatic access(input logic w, input logic r, input logic [8:0] a, input logic [31:0] d,
                          input bit chk_rd, output int l, output int l0, output logic e, output logic e0);
        logic [31:0] ev;
        @(negedge clk);
        wr = w; rd = r; addr = a; wdata = d;
        l = -1; l0 = -1;
        do begin
            @(posedge clk);
            l++;
            @(negedge clk);
            if (l0 < 0 && done0) l0 = l;
        end while (!done && l < 20);
        e = merr; e0 = merr0;
        check("done_rise", done, 1'b1);
        check("latency", l, 4);
        check("latency_ws0", l0, 2);
        check("busy_in_done", busy, 1'b1);
        if (chk_rd) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1'b1, 1'b0);
            end else begin
                ev = exp_q.pop_front();
                check("rd_data", rdata, ev);
                check("rd_data_ws0", rdata0, ev);
            end
        end
    endtask

    task automatic release_req(input string tag);
        wr = 1'b0; rd = 1'b0;
        @(negedge clk);
        check({tag, "_done_low"}, {done, done0}, 2'b00);
        check({tag, "_busy_low"}, {busy, busy0}, 2'b00);
        check({tag, "_merr_low"}, {merr, merr0}, 2'b00);
    endtask

    task automatic do_write(input logic [8:0] a, input logic [31:0] d, input string tag);
        access(1'b1, 1'b0, a, d, 1'b0, lat, lat0, err, err0);
        mdl[int'(a)] = d;
        release_req(tag);
    endtask

    task automatic do_read(input logic [8:0] a, input string tag);
        exp_q.push_back(mdl.exists(int'(a)) ? mdl[int'(a)] : 32'h0);
        access(1'b0, 1'b1, a, 32'h0, 1'b1, lat, lat0, err, err0);
        release_req(tag);
    endtask

    initial begin
        #12;
        check("rst_rd_data", rdata, 32'h0);
        check("rst_done_busy", {done, busy}, 2'b00);
        check("rst_merr", merr, 1'b0);
        check("rst_ws0", {rdata0, done0, busy0, merr0}, 35'h0);
        rst_n = 1'b1;

        do_write(9'h020, 32'hDEADBEEF, "w020");
        check("w020_merr", err, 1'b0);
        do_read(9'h020, "r020");

        // Reset one edge after sampling: both instances abort before their ACCESS edge
        @(negedge clk);
        wr = 1'b1; addr = 9'h020; wdata = 32'h11111111;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midwait_rst_busy", {busy, busy0}, 2'b00);
        check("midwait_rst_done", {done, done0}, 2'b00);
        check("midwait_rst_rd", rdata, 32'h0);
        @(negedge clk);
        wr = 1'b0; rst_n = 1'b1;
        do_read(9'h020, "r020_after_rst");

        access(1'b1, 1'b1, 9'h030, 32'h5, 1'b0, lat, lat0, err, err0);
        mdl[32'h30] = 32'h5;
        check("rdwr_rd_unchanged", rdata, 32'hDEADBEEF);
        release_req("rdwr030");
        do_read(9'h030, "r030");

        exp_q.push_back(32'h5);
        access(1'b0, 1'b1, 9'h030, 32'h0, 1'b1, lat, lat0, err, err0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_done_busy", {done, busy, done0, busy0}, 4'b1111);
        end
        check("hold_rd_data", rdata, 32'h5);
        release_req("hold");

        do_write(9'h1FF, 32'h12345678, "w1ff");
        do_read(9'h1FF, "r1ff");

`ifdef MEM_PROTECT_EN
        access(1'b0, 1'b1, 9'h005, 32'h0, 1'b0, lat, lat0, err, err0);
        base5 = rdata;
        release_req("base005");
        access(1'b1, 1'b0, 9'h005, 32'hFFFFFFFF, 1'b0, lat, lat0, err, err0);
        check("prot_merr_pulse", {err, err0}, 2'b11);
        mdl[5] = base5;
`else
        base5 = 32'h0;
        access(1'b1, 1'b0, 9'h005, 32'hFFFFFFFF, 1'b0, lat, lat0, err, err0);
        check("noprot_merr", {err, err0}, 2'b00);
        mdl[5] = 32'hFFFFFFFF;
`endif
        release_req("w005");
        do_read(9'h005, "r005");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
